// File: rtl/snake_pkg.sv
// Shared types and frame constants for the snake animation controller.
// Also holds the frame-sequencing helper that both directions use.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [4:0] FRAME_A_FIRST = 5'd1;
  localparam logic [4:0] FRAME_A_LAST  = 5'd5;
  localparam logic [4:0] FRAME_B_FIRST = 5'd11;
  localparam logic [4:0] FRAME_B_LAST  = 5'd15;
  localparam logic [6:0] SEG_BLANK     = 7'b1111111;

  function automatic logic [4:0] first_frame(input logic rev);
    return rev ? FRAME_B_LAST : FRAME_A_FIRST;
  endfunction

  // Walks the two frame runs 1..5 and 11..15 as one ring; anything off the
  // ring restarts at the first frame of the requested direction.
  function automatic logic [4:0] next_frame(input logic [4:0] cur, input logic rev);
    logic [4:0] nxt;
    nxt = first_frame(rev);
    if (!rev) begin
      if (cur == FRAME_A_LAST) begin
        nxt = FRAME_B_FIRST;
      end else if (cur == FRAME_B_LAST) begin
        nxt = FRAME_A_FIRST;
      end else if ((cur >= FRAME_A_FIRST && cur < FRAME_A_LAST) ||
                   (cur >= FRAME_B_FIRST && cur < FRAME_B_LAST)) begin
        nxt = cur + 5'd1;
      end
    end else begin
      if (cur == FRAME_B_FIRST) begin
        nxt = FRAME_A_LAST;
      end else if (cur == FRAME_A_FIRST) begin
        nxt = FRAME_B_LAST;
      end else if ((cur > FRAME_A_FIRST && cur <= FRAME_A_LAST) ||
                   (cur > FRAME_B_FIRST && cur <= FRAME_B_LAST)) begin
        nxt = cur - 5'd1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/snake_tick.sv
// Step prescaler: tick is asserted while enabled and the count has reached
// (STEP_DIV >> speed) - 1; the count then wraps to zero on that edge.
module snake_tick #(
  parameter int STEP_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int CW = $clog2(STEP_DIV);

  logic [CW-1:0] cnt_q, cnt_d, term;

  // >= rather than == so a speed increase past the current count fires at once
  always_comb begin
    term  = CW'((STEP_DIV >> speed) - 1);
    tick  = en && (cnt_q >= term);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_ctrl.sv
// Seven-segment snake animation sequencer: steps a frame address through an
// external pattern ROM and registers the returned segment pattern.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int STEP_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       dir,
  input  logic [1:0] speed,
  output logic [4:0] rom_addr,
  input  logic [6:0] rom_data,
  output logic [6:0] seg,
  output logic       dpt,
  output logic       step,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic [6:0] seg_q, seg_d;
  logic       step_q, step_d;
  logic       tick_en, tick_clr, tick;

  // Prescaler runs in PAUSE too once hold drops, so the release edge counts.
  assign tick_en  = (state_q != IDLE) && !hold && !stop;
  assign tick_clr = (state_q == IDLE) || stop;

  snake_tick #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (tick_en),
    .clr   (tick_clr),
    .speed (speed),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          addr_d  = first_frame(dir);
          step_d  = 1'b1;
        end
      end
      RUN, PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          addr_d  = '0;
        end else begin
          state_d = hold ? PAUSE : RUN;
          if (tick) begin
            addr_d = next_frame(addr_q, dir);
            step_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
    // Blank on both sides of IDLE so frame 0 never reaches the display.
    seg_d = (state_q == IDLE || state_d == IDLE) ? SEG_BLANK : rom_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      seg_q   <= SEG_BLANK;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seg_q   <= seg_d;
      step_q  <= step_d;
    end
  end

  assign rom_addr = addr_q;
  assign seg      = seg_q;
  assign step     = step_q;
  assign busy     = (state_q != IDLE);
  assign dpt      = 1'b1;

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 5_000_000, clocks per animation step at speed 0; legal minimum 4.
REQ-002 Port clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port start  input  1  level-sampled; begins animation from IDLE.
REQ-005 Port stop  input  1  level-sampled; returns to IDLE.
REQ-006 Port hold  input  1  while high, animation frozen (prescaler and address held).
REQ-007 Port dir  input  1  0 = forward frame order, 1 = reverse.
REQ-008 Port speed  input  2  step period = STEP_DIV >> speed clocks.
REQ-009 Port rom_addr  output  5  frame address to segment-pattern ROM.
REQ-010 Port rom_data  input  7  active-low segment pattern returned combinationally by ROM.
REQ-011 Port seg  output  7  registered active-low segment drive.
REQ-012 Port dpt  output  1  decimal point, active-low; constant 1 (off).
REQ-013 Port step  output  1  one-clock pulse on each rom_addr advance.
REQ-014 Port busy  output  1  high in RUN or PAUSE.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE.
REQ-016 IDLE: rom_addr = 0, prescaler cleared, busy = 0; start=1 and stop=0 -> RUN.
REQ-017 On entry to RUN from IDLE, rom_addr SHALL load 1 (dir=0) or 15 (dir=1) in the same edge, with step pulsed.
REQ-018 RUN: prescaler counts each clock; at count = (STEP_DIV >> speed) - 1 it clears, rom_addr advances one frame, step = 1 for that cycle.
REQ-019 Forward order SHALL be 1,2,3,4,5,11,12,13,14,15, then wrap to 1.
REQ-020 Reverse order SHALL be 15,14,13,12,11,5,4,3,2,1, then wrap to 15.
REQ-021 dir SHALL be sampled only at an advance; a change mid-period reverses from the current frame (e.g. at 11 with dir=1 next is 5).
REQ-022 RUN with hold=1 -> PAUSE; PAUSE with hold=0 -> RUN; prescaler count and rom_addr retained across PAUSE.
REQ-023 stop=1 in RUN or PAUSE -> IDLE next edge; stop SHALL win over start and hold when simultaneous.
REQ-024 start while RUN or PAUSE SHALL be ignored.
REQ-025 speed change mid-period: if current count already >= new terminal value, advance occurs on the next clock.
REQ-026 seg SHALL equal rom_data registered, one clock after rom_addr; in IDLE, seg = 7'b1111111.
REQ-027 Prescaler width SHALL be clog2(STEP_DIV); no overflow for any speed.
REQ-028 rom_addr SHALL never take a value outside {0,1..5,11..15}.

Reset
REQ-029 rst=1 SHALL force IDLE, rom_addr = 0, seg = 7'b1111111, step = 0, busy = 0, prescaler = 0, regardless of state, on the next edge.
REQ-030 rst SHALL dominate start, stop and hold.

Structure
REQ-031 Package snake_pkg SHALL hold the state enum and constants FRAME_A_FIRST=1, FRAME_A_LAST=5, FRAME_B_FIRST=11, FRAME_B_LAST=15, SEG_BLANK=7'b1111111.
REQ-032 Prescaler SHALL be sub-module snake_tick (ports clk, rst, en, clr, speed, tick).
REQ-033 The ROM is instantiated outside snake_ctrl; no pattern storage inside the block.

Verification (STEP_DIV=4)
REQ-034 rst, then start=1 one clock, dir=0, speed=0 -> rom_addr 1, then 2 four clocks later; step pulses exactly at each advance.
REQ-035 Run forward 10 steps from 1 -> sequence 1..5,11..15 then 1; at 5->11 seg becomes 7'b1110111 one clock after rom_addr=11.
REQ-036 dir=1 from start -> 15,14,13,12,11,5,...,1,15; flip dir to 0 at 11 -> next 12.
REQ-037 hold=1 for 7 clocks mid-period at count 2 -> rom_addr and count frozen, busy=1; release -> advance after exactly 2 further clocks (count reaches 3, advance on next edge).
REQ-038 start=1 and stop=1 together in RUN -> IDLE, rom_addr=0, seg=7'b1111111 one clock later.
REQ-039 rst mid-RUN at rom_addr=13 -> all outputs at reset values next edge; speed=1 then gives 2-clock step period.
